uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-stream frame decoder sitting directly downstream of `uart_rx`. It consumes the `rx_data`/`rx_rd` byte strobe and hunts for sync-delimited, checksummed command frames. Payload bytes go into a small internal buffer. Each good frame produces a one-cycle `frame_ok` pulse plus latched command, length and a 16-bit display word that feeds the `seven_segment` digits. Malformed or stalled frames are dropped and counted.

## Interface

Parameters:
- `MAX_LEN`, 16: maximum payload bytes accepted (1..255); sets buffer depth.
- `TIMEOUT`, 50000: idle clock cycles allowed between bytes inside a frame (1 ms at 50 MHz).
- `SYNC`, 8'hA5: frame start byte.

Ports:
- `clk`, in, 1: 50 MHz system clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte from `uart_rx`; valid only while `rx_rd`=1.
- `rx_rd`, in, 1: one-cycle byte-valid strobe, synchronous to `clk`.
- `rd_addr`, in, clog2(MAX_LEN): payload buffer read address.
- `rd_data`, out, 8: payload buffer byte at `rd_addr`; registered, 1-cycle latency.
- `frame_ok`, out, 1: one-cycle pulse on each good frame.
- `frame_cmd`, out, 8: command byte of the last good frame.
- `frame_len`, out, 8: payload length of the last good frame.
- `disp_word`, out, 16: `{payload[1], payload[0]}` of the last good frame with len ≥ 2.
- `err_cnt`, out, 8: saturating count of dropped frames.
- `busy`, out, 1: high whenever the state is not HUNT.

## Operation

Frame format: `SYNC`, CMD, LEN, LEN payload bytes, CSUM. CSUM is CMD ^ LEN ^ each payload byte (8-bit XOR).

State machine advances only on `rx_rd`, except for timeout:
- HUNT: byte == SYNC → CMD. Any other byte is discarded silently, with no error.
- CMD: latch byte into shadow cmd; clear running XOR to that byte → LEN.
- LEN: if byte > MAX_LEN, error → HUNT. If byte == 0 → CSUM. Otherwise latch length, clear payload index, XOR byte in → PAYLOAD.
- PAYLOAD: write byte to buffer[index], XOR in, increment index. After the LEN-th byte → CSUM. A byte equal to SYNC here is treated as ordinary data.
- CSUM: byte == running XOR → good frame, otherwise error. Both → HUNT.

Good frame:
- Pulse `frame_ok`; `frame_cmd`/`frame_len` ← shadow values.
- `disp_word` update depends on len: len ≥ 2 → `{buf[1], buf[0]}`; len == 1 → `{8'h00, buf[0]}`; len == 0 → unchanged.

Error: `err_cnt` increments by 1 and saturates at 8'hFF. No other output changes.

Timeout:
- An idle counter runs in every state except HUNT and clears on each `rx_rd`.
- Reaching TIMEOUT with no `rx_rd` in that cycle counts as an error → HUNT.
- If `rx_rd` arrives in the same cycle the counter hits TIMEOUT, the byte wins and no error is counted.

Buffer:
- Written in place during PAYLOAD.
- Contents are guaranteed only between `frame_ok` and the next frame's first payload byte.
- Reads beyond `frame_len` return stale data.

## Timing

- Reset values: state HUNT, `frame_ok` 0, `frame_cmd` 0, `frame_len` 0, `disp_word` 0, `err_cnt` 0, `busy` 0, `rd_data` 0, idle counter 0. Buffer contents undefined.
- `frame_ok` and the updated `frame_cmd`/`frame_len`/`disp_word`/`err_cnt` appear in the cycle after the `clk` edge that samples the CSUM `rx_rd`. That is 1-cycle latency.
- `busy` rises 1 cycle after the SYNC strobe and falls 1 cycle after the terminating event (CSUM, LEN error or timeout).
- `rx_rd` held high for several cycles counts as several bytes; upstream guarantees single-cycle pulses.
- Back-to-back frames with zero gap are supported: a SYNC may arrive the cycle after CSUM.
- `reset` asserted mid-frame aborts immediately to HUNT. Nothing is counted and the frame is lost.

## Test plan

- Frame A5 01 02 34 12 25 → one `frame_ok` pulse; `frame_cmd`=01, `frame_len`=02, `disp_word`=16'h1234, `err_cnt`=0; reading addr 0 and 1 gives 34, 12.
- Same frame with CSUM 26 → no `frame_ok`; `err_cnt`=1; `disp_word` keeps its prior value.
- Bytes 00 FF 5A, then A5 07 01 A5 A3 → garbage ignored with `err_cnt` unchanged; SYNC accepted as payload; good frame with `disp_word`=16'h00A5.
- A5 01 11 with MAX_LEN=16 → `err_cnt`+1 and `busy` low 1 cycle after the LEN strobe. A following A5 02 00 02 → good frame with `frame_len`=0 and `disp_word` unchanged.
- A5 01 02 34, then silence for TIMEOUT cycles → `err_cnt`+1 and return to HUNT. Repeat with a byte landing exactly on cycle TIMEOUT → no error.
- 256 bad-checksum frames → `err_cnt` saturates at FF. `reset` asserted during PAYLOAD → all outputs return to reset values and the next valid frame decodes correctly.

Source files
------------

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - sync-delimited, XOR-checksummed command frame decoder
module uart_frame_parser #(
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] SYNC    = 8'hA5,
  localparam int        AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int        CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_rd,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_ok,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  output logic [15:0]   disp_word,
  output logic [7:0]    err_cnt,
  output logic          busy
);
  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CSUM} state_t;

  localparam logic [7:0]    MAX_LEN8  = 8'(MAX_LEN);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [7:0]    cmd_q, cmd_d, len_q, len_d, idx_q, idx_d, xor_q, xor_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic          frame_ok_q, frame_ok_d;
  logic [7:0]    frame_cmd_q, frame_cmd_d, frame_len_q, frame_len_d;
  logic [15:0]   disp_q, disp_d;
  logic [7:0]    err_q, err_d, rd_data_q, rd_data_d;
  logic [7:0]    mem_q [2**AW];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          timeout, len_bad, last_pay, csum_hit, good, bad;

  always_comb begin
    timeout  = (state_q != HUNT) && !rx_rd && (idle_q == IDLE_LAST);
    len_bad  = rx_data > MAX_LEN8;
    last_pay = (idx_q + 8'd1) == len_q;
    csum_hit = rx_data == xor_q;
    good     = rx_rd && (state_q == CSUM) && csum_hit;
    bad      = timeout ||
               (rx_rd && (((state_q == LEN) && len_bad) || ((state_q == CSUM) && !csum_hit)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      idle_q      <= '0;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      frame_ok_q  <= 1'b0;
      frame_cmd_q <= '0;
      frame_len_q <= '0;
      disp_q      <= '0;
      err_q       <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      frame_ok_q  <= frame_ok_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      disp_q      <= disp_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Payload storage has no reset; contents are only meaningful after a good frame.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= rx_data;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = HUNT;
    end else if (rx_rd) begin
      case (state_q)
        HUNT:    if (rx_data == SYNC) state_d = CMD;
        CMD:     state_d = LEN;
        LEN: begin
          if (len_bad)              state_d = HUNT;
          else if (rx_data == 8'd0) state_d = CSUM;
          else                      state_d = PAYLOAD;
        end
        PAYLOAD: if (last_pay) state_d = CSUM;
        CSUM:    state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    idle_d  = (state_q == HUNT || rx_rd || timeout) ? '0 : idle_q + CW'(1);
    cmd_d   = cmd_q;
    len_d   = len_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    wr_en   = 1'b0;
    wr_addr = idx_q[AW-1:0];
    if (rx_rd) begin
      case (state_q)
        CMD: begin
          cmd_d = rx_data;
          xor_d = rx_data;
        end
        LEN: begin
          len_d = rx_data;
          idx_d = '0;
          xor_d = xor_q ^ rx_data;
        end
        PAYLOAD: begin
          wr_en = 1'b1;
          idx_d = idx_q + 8'd1;
          xor_d = xor_q ^ rx_data;
          // First two payload bytes are mirrored for the display word.
          if (idx_q == 8'd0) b0_d = rx_data;
          if (idx_q == 8'd1) b1_d = rx_data;
        end
        default: ;
      endcase
    end
    frame_ok_d  = good;
    frame_cmd_d = good ? cmd_q : frame_cmd_q;
    frame_len_d = good ? len_q : frame_len_q;
    disp_d      = disp_q;
    if (good && len_q >= 8'd2)      disp_d = {b1_q, b0_q};
    else if (good && len_q == 8'd1) disp_d = {8'h00, b0_q};
    err_d     = (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    rd_data_d = mem_q[rd_addr];
  end

  assign rd_data   = rd_data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_cmd = frame_cmd_q;
  assign frame_len = frame_len_q;
  assign disp_word = disp_q;
  assign err_cnt   = err_q;
  assign busy      = state_q != HUNT;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
  localparam int MAXL = 16;
  localparam int TO   = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rd = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [7:0]  rd_data;
  logic        frame_ok;
  logic [7:0]  frame_cmd;
  logic [7:0]  frame_len;
  logic [15:0] disp_word;
  logic [7:0]  err_cnt;
  logic        busy;

  uart_frame_parser #(.MAX_LEN(MAXL), .TIMEOUT(TO), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_rd(rx_rd),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ok(frame_ok),
    .frame_cmd(frame_cmd), .frame_len(frame_len), .disp_word(disp_word),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [15:0] disp;
    logic [7:0]  err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  txq[$];
  logic [7:0]  pl[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_err = 8'h00;
  logic [15:0] exp_disp = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic bump_err();
    exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
  endtask

  task automatic add_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] cflip);
    logic [7:0] x;
    exp_t e;
    txq.push_back(8'hA5);
    txq.push_back(cmd);
    txq.push_back(len);
    x = cmd ^ len;
    for (int i = 0; i < int'(len); i++) begin
      txq.push_back(pl[i]);
      x = x ^ pl[i];
    end
    txq.push_back(x ^ cflip);
    if (cflip != 8'h00) begin
      bump_err();
    end else begin
      if (len >= 8'd2)      exp_disp = {pl[1], pl[0]};
      else if (len == 8'd1) exp_disp = {8'h00, pl[0]};
      e.cmd = cmd; e.len = len; e.disp = exp_disp; e.err = exp_err;
      sb.push_back(e);
    end
  endtask

  task automatic flush(input bit gap);
    while (txq.size() > 0) begin
      @(negedge clk);
      rx_data = txq.pop_front();
      rx_rd = 1'b1;
      if (gap) begin
        @(negedge clk);
        rx_rd = 1'b0;
      end
    end
    if (!gap) begin
      @(negedge clk);
      rx_rd = 1'b0;
    end
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk("rd_data", rd_data, e);
  endtask

  task automatic chk_reset_vals();
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_cmd", frame_cmd, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_disp", disp_word, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && frame_ok) begin
      if (sb.size() == 0) begin
        chk("spurious_frame_ok", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("frame_cmd", frame_cmd, e.cmd);
        chk("frame_len", frame_len, e.len);
        chk("disp_word", disp_word, e.disp);
        chk("err_at_ok", err_cnt, e.err);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    pl = '{8'h34, 8'h12};
    add_frame(8'h01, 8'h02, 8'h00);
    flush(1'b1);
    chk("ok_latency", frame_ok, 1);
    @(negedge clk);
    chk("ok_one_cycle", frame_ok, 0);
    rd_chk(4'd0, 8'h34);
    rd_chk(4'd1, 8'h12);

    add_frame(8'h01, 8'h02, 8'h03);
    flush(1'b1);
    chk("bad_csum_no_ok", frame_ok, 0);
    chk("bad_csum_err", err_cnt, exp_err);
    chk("bad_csum_disp", disp_word, 16'h1234);

    txq = '{8'h00, 8'hFF, 8'h5A};
    flush(1'b1);
    chk("garbage_busy", busy, 0);
    chk("garbage_err", err_cnt, exp_err);
    pl = '{8'hA5};
    add_frame(8'h07, 8'h01, 8'h00);
    flush(1'b1);
    chk("sync_payload_ok", frame_ok, 1);

    txq = '{8'hA5, 8'h01, 8'h11};
    flush(1'b1);
    bump_err();
    chk("len_err_busy", busy, 0);
    chk("len_err_cnt", err_cnt, exp_err);
    pl.delete();
    add_frame(8'h02, 8'h00, 8'h00);
    flush(1'b1);
    chk("len0_ok", frame_ok, 1);

    pl.delete();
    for (int i = 0; i < MAXL; i++) pl.push_back(8'(i * 17 + 3));
    add_frame(8'h03, 8'(MAXL), 8'h00);
    flush(1'b0);
    chk("maxlen_ok", frame_ok, 1);
    rd_chk(4'd15, 8'(15 * 17 + 3));

    txq = '{8'hA5, 8'h01, 8'h02, 8'h34};
    flush(1'b1);
    repeat (TO - 1) @(negedge clk);
    chk("timeout_pre_busy", busy, 1);
    @(negedge clk);
    bump_err();
    chk("timeout_busy", busy, 0);
    chk("timeout_err", err_cnt, exp_err);

    txq = '{8'hA5, 8'h01, 8'h02, 8'h34};
    flush(1'b1);
    repeat (TO - 2) @(negedge clk);
    txq = '{8'h12};
    flush(1'b1);
    chk("edge_byte_busy", busy, 1);
    chk("edge_byte_err", err_cnt, exp_err);
    begin
      exp_t e;
      exp_disp = 16'h1234;
      e.cmd = 8'h01; e.len = 8'h02; e.disp = exp_disp; e.err = exp_err;
      sb.push_back(e);
    end
    txq = '{8'h25};
    flush(1'b1);
    chk("edge_byte_ok", frame_ok, 1);

    pl = '{8'hAB, 8'hCD};
    add_frame(8'h05, 8'h02, 8'h00);
    pl = '{8'hEF};
    add_frame(8'h06, 8'h01, 8'h00);
    flush(1'b0);
    chk("b2b_ok", frame_ok, 1);

    pl.delete();
    for (int i = 0; i < 256; i++) add_frame(8'h08, 8'h00, 8'h01);
    flush(1'b0);
    @(negedge clk);
    chk("err_saturate", err_cnt, 8'hFF);

    txq = '{8'hA5, 8'h03, 8'h04, 8'h11, 8'h22};
    flush(1'b1);
    chk("mid_frame_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    exp_err = 8'h00;
    exp_disp = 16'h0000;
    pl = '{8'h56, 8'h78};
    add_frame(8'h09, 8'h02, 8'h00);
    flush(1'b1);
    chk("post_reset_ok", frame_ok, 1);
    rd_chk(4'd1, 8'h78);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("final_err", err_cnt, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
